timer_datapath: RTL
===================

# timer_datapath

Countdown datapath for the egg timer; the responder end of the controller's enable/strobe interface. Consumes `swSecEn`, `swMinEn`, `secsSet`, `minsSet`, `decEn`, `flashEn` and returns `isTimeFlat`. Holds the minutes:seconds count, loads it from the switches, decrements it once per second, and drives the alarm LED flash. Sits between the switch inputs, the timer controller and the display/LED drivers.

## Interface
- `TICK_DIV`, 50_000_000, `clk` cycles per one-second decrement tick (≥2).
- `FLASH_DIV`, 25_000_000, `clk` cycles per LED toggle in flash (≥2).
- `clk`  in  1  system clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-low reset.
- `sw`  in  6  switch value, binary; shared by the seconds and minutes entry.
- `swSecEn`  in  1  controller is in SetSec; preview `sw` on `secs`.
- `swMinEn`  in  1  controller is in SetMin; preview `sw` on `mins`.
- `secsSet`  in  1  load strobe for the seconds register.
- `minsSet`  in  1  load strobe for the minutes register.
- `decEn`  in  1  countdown running.
- `flashEn`  in  1  alarm flashing.
- `secs`  out  6  displayed seconds, 0..59.
- `mins`  out  6  displayed minutes, 0..59.
- `isTimeFlat`  out  1  high when the stored count is 00:00.
- `led`  out  1  alarm LED.

## Operation
- Registers: `secReg`, `minReg` (6 b each); tick prescaler; flash prescaler; `ledReg`.
- Load: on posedge with `secsSet`=1, `secReg` ← `sw` after range check; `minsSet` likewise loads `minReg`. Both strobes high loads both.
- Range check: `sw` ≤ 59 loads as-is. For `sw` > 59, see Configuration.
- Preview: `secs` = `swSecEn` ? checked `sw` : `secReg`; `mins` = `swMinEn` ? checked `sw` : `minReg`. These paths are combinational.
- Tick: while `decEn`=1 the prescaler counts 0..TICK_DIV−1 and wraps. Wrap produces a one-cycle `tick`. While `decEn`=0 the prescaler is held at 0, so each run starts with a full second.
- Decrement on `tick` and not flat:
  - `secReg`≠0: `secReg`−1.
  - `secReg`=0: `secReg`←59, `minReg`−1.
  - At 00:00 the count holds; it never wraps below zero.
- `isTimeFlat` = (`secReg`==0 && `minReg`==0), combinational from the registers.
- Flash: while `flashEn`=1 the flash prescaler counts 0..FLASH_DIV−1 and `ledReg` toggles on each wrap. When `flashEn` rises, `ledReg`=1 in the first cycle. `flashEn`=0 clears the prescaler and `ledReg`. `led` = `ledReg`.
- Priority when strobes coincide: a load beats a decrement in the same cycle. The tick is consumed and the count is not decremented.
- `flashEn` and `decEn` are independent. If both are high (illegal from the controller), both act.

## Timing
- Reset (`reset`=0, async) sets:
  - `secReg`=`minReg`=0, both prescalers=0, `ledReg`=0.
  - Outputs: `secs`=`mins`=0 (when the preview enables are low), `isTimeFlat`=1, `led`=0.
- Load latency: the loaded value appears on `secs`/`mins` and `isTimeFlat` right after the load edge (1 cycle).
- First decrement occurs TICK_DIV cycles after the first posedge with `decEn`=1. Later decrements occur every TICK_DIV cycles.
- `isTimeFlat` rises in the same cycle the register reaches 00:00. It has no extra pipeline delay.
- Strobes are sampled on posedge. The controller updates on negedge, so its strobes are stable for a half cycle. Single-cycle strobes are sufficient.
- Reset mid-countdown or mid-flash aborts immediately to the reset values.

## Configuration
- `TIMER_SW_CLAMP_EN` defined: `sw` > 59 saturates to 59, for both load and preview.
- Not defined: `sw` > 59 is rejected.
  - The load leaves the register unchanged.
  - The preview shows the current register value.

## Structure
- Package `timer_pkg`:
  - `TIME_W`=6.
  - `MAX_SEC`=59, `MAX_MIN`=59.
  - `typedef logic [TIME_W-1:0] time_t`.
  - Function `sw_check(sw, cur)` implementing the range rule under `TIMER_SW_CLAMP_EN`.
- One sub-module, `tick_gen`: parameter DIV; inputs `clk`, `reset`, `en`; output `tick`. It counts while `en` is high and clears when `en` is low. It is instantiated twice, for the seconds tick and the flash toggle.

## Test plan
Run with `TICK_DIV`=4 and `FLASH_DIV`=2.
- Reset value: drive `reset`=0 → `secs`=0, `mins`=0, `isTimeFlat`=1, `led`=0.
- Load and borrow: `sw`=5 with `secsSet` pulse, `sw`=1 with `minsSet` pulse → 01:05, `isTimeFlat`=0. Hold `decEn`=1 for 24 cycles → 00:59.
- Count to flat: load 00:02, `decEn`=1 → 00:01 after 4 cycles and 00:00 after 8 cycles, `isTimeFlat`=1 in that cycle. The count holds at 00:00 for a further 8 cycles.
- Pause/resume: load 00:10, run 6 cycles (→00:09), drop `decEn` 10 cycles, re-raise → 00:08 exactly 4 cycles after the re-raise.
- Range rule: `sw`=63 with `secsSet` over a stored 12:
  - With `TIMER_SW_CLAMP_EN` → `secs`=59.
  - Without → `secs` stays 12.
  - `swSecEn`=1 preview matches in each build.
- Flash and priority:
  - `flashEn`=1 → `led` 1,1,0,0,1… (toggling every 2 cycles); `flashEn`=0 → `led`=0 next cycle.
  - `secsSet` coincident with `tick` → the loaded value wins, with no decrement.

Source files
------------

// File: rtl/timer_datapath_pkg.sv
// Shared types, limits and switch range rule for the egg-timer datapath.
// TIMER_SW_CLAMP_EN: saturate out-of-range switch values to 59 instead of rejecting them.
package timer_pkg;

   localparam int TIME_W = 6;

   typedef logic [TIME_W-1:0] time_t;

   localparam time_t MAX_SEC = 6'd59;
   localparam time_t MAX_MIN = 6'd59;

   function automatic time_t sw_check(input time_t sw, input time_t cur);
      if (sw <= MAX_SEC) return sw;
`ifdef TIMER_SW_CLAMP_EN
      return MAX_SEC;
`else
      return cur;
`endif
   endfunction

endpackage

// File: rtl/timer_datapath_if.sv
// Controller <-> datapath enable/strobe bundle.
// The controller is the master; the datapath answers with isTimeFlat.
interface timer_datapath_if;

   logic swSecEn;
   logic swMinEn;
   logic secsSet;
   logic minsSet;
   logic decEn;
   logic flashEn;
   logic isTimeFlat;

   modport master (
      output swSecEn, swMinEn, secsSet, minsSet, decEn, flashEn,
      input  isTimeFlat
   );

   modport slave (
      input  swSecEn, swMinEn, secsSet, minsSet, decEn, flashEn,
      output isTimeFlat
   );

endinterface

// File: rtl/timer_datapath_tick_gen.sv
// Free-running divide-by-DIV prescaler; one-cycle tick on wrap.
// Held at zero while en is low so every run starts with a full period.
module tick_gen #(
   parameter int unsigned DIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   output logic tick
);

   localparam int W = (DIV > 2) ? $clog2(DIV) : 1;

   logic [W-1:0] cnt_q, cnt_d;

   assign tick = en && (cnt_q == W'(DIV - 1));

   // next prescaler value: clear when idle or on wrap
   always_comb begin
      cnt_d = cnt_q + W'(1);
      if (!en || tick) cnt_d = '0;
   end

   // prescaler register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/timer_datapath.sv
// Egg-timer countdown datapath: mm:ss load/preview, 1 Hz countdown, alarm flash.
// TIMER_SW_CLAMP_EN selects clamp (defined) or reject (default) for sw > 59.
module timer_datapath
   import timer_pkg::*;
#(
   parameter int unsigned TICK_DIV  = 50_000_000,
   parameter int unsigned FLASH_DIV = 25_000_000
) (
   input  logic            clk,
   input  logic            reset,
   input  time_t           sw,
   timer_datapath_if.slave ctl,
   output time_t           secs,
   output time_t           mins,
   output logic            led
);

   time_t sec_q, sec_d;
   time_t min_q, min_d;
   logic  led_q, led_d;
   logic  fl_q;
   logic  tick, ftick, flash_run;
   logic  flat, load, dec;

   // flash prescaler starts one cycle after the rise so the LED stays lit for a full period
   assign flash_run = ctl.flashEn && fl_q;

   tick_gen #(.DIV(TICK_DIV)) u_sec_tick (
      .clk   (clk),
      .reset (reset),
      .en    (ctl.decEn),
      .tick  (tick)
   );

   tick_gen #(.DIV(FLASH_DIV)) u_flash_tick (
      .clk   (clk),
      .reset (reset),
      .en    (flash_run),
      .tick  (ftick)
   );

   assign flat           = (sec_q == '0) && (min_q == '0);
   assign ctl.isTimeFlat = flat;
   assign load           = ctl.secsSet || ctl.minsSet;
   assign dec            = tick && !flat && !load;

   assign secs = ctl.swSecEn ? sw_check(sw, sec_q) : sec_q;
   assign mins = ctl.swMinEn ? sw_check(sw, min_q) : min_q;
   assign led  = led_q;

   // count update: a load swallows a coincident tick
   always_comb begin
      sec_d = sec_q;
      min_d = min_q;
      if (dec) begin
         if (sec_q != '0) begin
            sec_d = sec_q - time_t'(1);
         end else begin
            sec_d = MAX_SEC;
            min_d = min_q - time_t'(1);
         end
      end
      if (ctl.secsSet) sec_d = sw_check(sw, sec_q);
      if (ctl.minsSet) min_d = sw_check(sw, min_q);
   end

   // LED: lit on the rise, toggles on each flash wrap, dark when idle
   always_comb begin
      led_d = 1'b0;
      if (ctl.flashEn) begin
         if (!fl_q) led_d = 1'b1;
         else       led_d = led_q ^ ftick;
      end
   end

   // state registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sec_q <= '0;
         min_q <= '0;
         led_q <= 1'b0;
         fl_q  <= 1'b0;
      end else begin
         sec_q <= sec_d;
         min_q <= min_d;
         led_q <= led_d;
         fl_q  <= ctl.flashEn;
      end
   end

endmodule
